// File: rtl/score_digit_pkg.sv
// Shared constants, fetch FSM state type and glyph ROM address helper for the score digit fetcher.
// Consumers: score_digit_fetcher, score_line_buf.
package score_digit_pkg;

    localparam int GLYPH_W     = 8;
    localparam int GLYPH_H     = 16;
    localparam int GLYPH_BYTES = 128;
    localparam int ROM_AW      = 11;
    localparam int ROM_DW      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Glyph byte address: digit*128 + row*8 + col, i.e. {digit, row, col}.
    function automatic logic [ROM_AW-1:0] glyph_rom_addr(
        input logic [3:0] digit,
        input logic [3:0] row,
        input logic [2:0] col
    );
        return ROM_AW'(int'(digit) * GLYPH_BYTES + int'(row) * GLYPH_W + int'(col));
    endfunction

endpackage

// File: rtl/score_line_buf.sv
// One scanline of glyph bytes: synchronous write port, registered read port.
// The read data returns to zero whenever rd_en is low, so out-of-field pixels read as 0.
module score_line_buf #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_r [DEPTH];
    logic [DW-1:0] rd_data_r;

    // Line storage write
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered, gated read
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_r <= {DW{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end else begin
            rd_data_r <= {DW{1'b0}};
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/score_digit_fetcher.sv
// Fetches one glyph row per digit into a line buffer each score-band scanline, then streams palette indices by hcount.
// Optional build macro: SCORE_LEADING_ZERO_BLANK_EN (blank leading zero digits without ROM access).
module score_digit_fetcher
    import score_digit_pkg::*;
#(
    parameter int         N_DIGITS    = 4,
    parameter logic [9:0] X0          = 10'd16,
    parameter logic [9:0] Y0          = 10'd8,
    parameter logic [7:0] TRANSPARENT = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] score_bcd,
    input  logic                  score_load,
    input  logic                  line_start,
    input  logic [9:0]            line_num,
    input  logic [9:0]            hcount,
    output logic [ROM_AW-1:0]     rom_address,
    output logic                  rom_chipselect,
    output logic                  rom_clken,
    input  logic [ROM_DW-1:0]     rom_readdata,
    output logic                  pixel_valid,
    output logic [7:0]            pixel_index,
    output logic                  busy
);

    localparam int              SLOTS     = GLYPH_W * N_DIGITS;
    localparam int              SW        = $clog2(SLOTS);
    localparam logic [SW-1:0]   LAST_SLOT = SW'(SLOTS - 1);

    fetch_state_t              state_r, state_s;
    logic [SW-1:0]             slot_r, slot_s;
    logic [3:0]                row_r, row_s;
    logic [4*N_DIGITS-1:0]     score_r;
    logic [4*N_DIGITS-1:0]     fetch_score_r, fetch_score_s;
    logic                      pipe_valid_r, pipe_valid_s;
    logic [SW-1:0]             pipe_slot_r, pipe_slot_s;
    logic                      pipe_blank_r, pipe_blank_s;
    logic                      line_valid_r, line_valid_s;
    logic [ROM_AW-1:0]         rom_address_r, rom_address_s;
    logic                      fetching_r, fetching_s;
    logic                      busy_r, busy_s;
    logic                      wr_en_s;
    logic [7:0]                wr_data_s;
    logic                      in_band_s;
    logic [3:0]                band_row_s;
    logic                      in_range_s, in_range_r;
    logic [SW-1:0]             rd_idx_s;
    logic [7:0]                buf_rd_data_s;

    // Slot 0 is the most significant digit.
    function automatic logic [3:0] slot_digit(input logic [4*N_DIGITS-1:0] sc, input logic [SW-1:0] sl);
        int d;
        d = N_DIGITS - 1 - int'(sl >> 3);
        return sc[d*4 +: 4];
    endfunction

    function automatic logic slot_blank(input logic [4*N_DIGITS-1:0] sc, input logic [SW-1:0] sl);
        int   d;
        logic blank;
        d     = N_DIGITS - 1 - int'(sl >> 3);
        blank = (sc[d*4 +: 4] > 4'd9);
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        if ((d > 0) && ((sc >> (4*d)) == '0)) begin
            blank = 1'b1;
        end else begin
            blank = blank;
        end
`endif
        return blank;
    endfunction

    assign in_band_s  = (line_num >= Y0) && ({1'b0, line_num} < ({1'b0, Y0} + 11'(GLYPH_H)));
    assign band_row_s = 4'(line_num - Y0);
    assign wr_data_s  = pipe_blank_r ? TRANSPARENT : rom_readdata;

    // Next-state: line_start always wins and restarts (or cancels) the fetch
    always_comb begin
        state_s       = state_r;
        slot_s        = slot_r;
        row_s         = row_r;
        fetch_score_s = fetch_score_r;
        pipe_valid_s  = 1'b0;
        pipe_slot_s   = slot_r;
        pipe_blank_s  = 1'b0;
        line_valid_s  = line_valid_r;
        wr_en_s       = 1'b0;
        if (line_start) begin
            line_valid_s = 1'b0;
            if (in_band_s) begin
                state_s       = FETCH;
                slot_s        = '0;
                row_s         = band_row_s;
                fetch_score_s = score_r;
            end else begin
                state_s = IDLE;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                FETCH: begin
                    pipe_valid_s = 1'b1;
                    pipe_blank_s = slot_blank(fetch_score_r, slot_r);
                    wr_en_s      = pipe_valid_r;
                    if (slot_r == LAST_SLOT) begin
                        state_s = DRAIN;
                    end else begin
                        slot_s = slot_r + SW'(1);
                    end
                end
                DRAIN: begin
                    wr_en_s      = pipe_valid_r;
                    line_valid_s = 1'b1;
                    state_s      = IDLE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // ROM-side outputs for the slot presented next cycle; blanked digits park the address at 0
    always_comb begin
        fetching_s = (state_s == FETCH);
        busy_s     = (state_s != IDLE);
        if (fetching_s && !slot_blank(fetch_score_s, slot_s)) begin
            rom_address_s = glyph_rom_addr(slot_digit(fetch_score_s, slot_s), row_s, slot_s[2:0]);
        end else begin
            rom_address_s = '0;
        end
    end

    // Fetch state and registered ROM/status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            slot_r        <= '0;
            row_r         <= 4'd0;
            fetch_score_r <= '0;
            pipe_valid_r  <= 1'b0;
            pipe_slot_r   <= '0;
            pipe_blank_r  <= 1'b0;
            line_valid_r  <= 1'b0;
            rom_address_r <= '0;
            fetching_r    <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            slot_r        <= slot_s;
            row_r         <= row_s;
            fetch_score_r <= fetch_score_s;
            pipe_valid_r  <= pipe_valid_s;
            pipe_slot_r   <= pipe_slot_s;
            pipe_blank_r  <= pipe_blank_s;
            line_valid_r  <= line_valid_s;
            rom_address_r <= rom_address_s;
            fetching_r    <= fetching_s;
            busy_r        <= busy_s;
        end
    end

    // Frame score latch
    always_ff @(posedge clk) begin
        if (reset) begin
            score_r <= '0;
        end else if (score_load) begin
            score_r <= score_bcd;
        end else begin
            score_r <= score_r;
        end
    end

    assign in_range_s = line_valid_r && (hcount >= X0) &&
                        ({1'b0, hcount} < ({1'b0, X0} + 11'(SLOTS)));
    assign rd_idx_s   = SW'(hcount - X0);

    // In-field flag aligned with the buffer's registered read
    always_ff @(posedge clk) begin
        if (reset) begin
            in_range_r <= 1'b0;
        end else begin
            in_range_r <= in_range_s;
        end
    end

    score_line_buf #(
        .DEPTH (SLOTS),
        .AW    (SW),
        .DW    (8)
    ) u_line_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en_s),
        .wr_addr (pipe_slot_r),
        .wr_data (wr_data_s),
        .rd_en   (in_range_s),
        .rd_addr (rd_idx_s),
        .rd_data (buf_rd_data_s)
    );

    assign rom_address    = rom_address_r;
    assign rom_chipselect = fetching_r;
    assign rom_clken      = fetching_r;
    assign busy           = busy_r;
    assign pixel_index    = buf_rd_data_s;
    assign pixel_valid    = in_range_r && (buf_rd_data_s != TRANSPARENT);

endmodule

// File: tb/tb_score_digit_fetcher.sv
// Randomized self-checking bench for score_digit_fetcher against a glyph-table reference model.
// Expectations follow SCORE_LEADING_ZERO_BLANK_EN when it is defined.
module tb_score_digit_fetcher;

    localparam int ND = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] score_bcd;
    logic        score_load;
    logic        line_start;
    logic [9:0]  line_num;
    logic [9:0]  hcount;
    logic [10:0] rom_address;
    logic        rom_chipselect;
    logic        rom_clken;
    logic [7:0]  rom_readdata;
    logic        pixel_valid;
    logic [7:0]  pixel_index;
    logic        busy;

    logic [7:0]  rom [0:2047];
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          rom_oob = 0;

    score_digit_fetcher dut (
        .clk            (clk),
        .reset          (reset),
        .score_bcd      (score_bcd),
        .score_load     (score_load),
        .line_start     (line_start),
        .line_num       (line_num),
        .hcount         (hcount),
        .rom_address    (rom_address),
        .rom_chipselect (rom_chipselect),
        .rom_clken      (rom_clken),
        .rom_readdata   (rom_readdata),
        .pixel_valid    (pixel_valid),
        .pixel_index    (pixel_index),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Glyph ROM: one-cycle read latency, plus an out-of-range access monitor
    always @(posedge clk) begin
        if (rom_clken) rom_readdata <= rom[rom_address];
        if (rom_clken && rom_address > 11'd1279) rom_oob <= rom_oob + 1;
    end

    // Expected {pixel_valid, pixel_index} for column h given the displayed score/row
    function automatic logic [8:0] exp_pix(input logic [15:0] sc, input int row, input bit lv, input int h);
        int idx, d;
        logic [3:0] nib;
        bit blank;
        logic [7:0] b;
        if (!lv || h < 16 || h >= 16 + 8*ND) return 9'h000;
        idx   = h - 16;
        d     = ND - 1 - idx / 8;
        nib   = sc[d*4 +: 4];
        blank = (nib > 4'd9);
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        if (d > 0 && (sc >> (4*d)) == 16'h0000) blank = 1'b1;
`endif
        b = blank ? 8'h00 : rom[int'(nib)*128 + row*8 + idx%8];
        return {b != 8'h00, b};
    endfunction

    function automatic logic [15:0] rand_score();
        logic [15:0] s;
        for (int i = 0; i < 4; i++) s[i*4 +: 4] = 4'($urandom_range(0, 9));
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_score(input logic [15:0] v);
        score_bcd = v; score_load = 1'b1; tick(); score_load = 1'b0;
    endtask

    task automatic start_line(input int n);
        line_num = 10'(n); line_start = 1'b1; tick(); line_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({rom_address, rom_chipselect, rom_clken, pixel_valid, pixel_index, busy} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got addr=%0d cs=%b ce=%b pv=%b pi=%h busy=%b required all 0",
                     rom_address, rom_chipselect, rom_clken, pixel_valid, pixel_index, busy);
        end
        reset = 1'b0;
        for (int h = 15; h <= 48; h += 11) begin
            hcount = 10'(h); tick();
            n_cmp++;
            if ({pixel_valid, pixel_index} !== 9'h000) begin
                n_fail++; $display("FAIL reset_pixel h=%0d got %h required 000", h, {pixel_valid, pixel_index});
            end
        end
    endtask

    task automatic test_fetch_addresses();
        int busy_n = 0;
        logic [10:0] q[$];
        load_score(16'h1234);
        start_line(8);
        for (int i = 0; i < 40; i++) begin
            if (busy) busy_n++;
            if (rom_chipselect) q.push_back(rom_address);
            tick();
        end
        n_cmp++;
        if (busy_n != 33) begin n_fail++; $display("FAIL fetch_busy_len got %0d required 33", busy_n); end
        n_cmp++;
        if (q.size() != 32) begin n_fail++; $display("FAIL fetch_addr_count got %0d required 32", q.size()); end
        for (int p = 0; p < 32 && p < q.size(); p++) begin
            n_cmp++;
            if (int'(q[p]) != (p / 8 + 1) * 128 + p % 8) begin
                n_fail++; $display("FAIL fetch_addr slot=%0d got %0d required %0d", p, q[p], (p/8+1)*128 + p%8);
            end
        end
    endtask

    task automatic test_pixels();
        logic [15:0] sc;
        int row;
        logic [8:0] exp;
        for (int it = 0; it < 5; it++) begin
            sc  = (it == 0) ? 16'h0905 : rand_score();
            row = (it == 0) ? 2 : int'($urandom_range(0, 15));
            load_score(sc);
            start_line(8 + row);
            repeat (36) tick();
            for (int h = 14; h <= 50; h++) begin
                hcount = 10'(h); tick();
                exp = exp_pix(sc, row, 1'b1, h);
                n_cmp++;
                if ({pixel_valid, pixel_index} !== exp) begin
                    n_fail++;
                    $display("FAIL pixel sc=%h row=%0d h=%0d got %h required %h", sc, row, h, {pixel_valid, pixel_index}, exp);
                end
            end
        end
    endtask

    task automatic test_out_of_band();
        int lines[4];
        int cs_n;
        lines[0] = 7; lines[1] = 24;
        lines[2] = int'($urandom_range(25, 1023)); lines[3] = int'($urandom_range(0, 6));
        for (int k = 0; k < 4; k++) begin
            cs_n = 0;
            start_line(lines[k]);
            for (int i = 0; i < 40; i++) begin
                if (rom_chipselect) cs_n++;
                tick();
            end
            n_cmp++;
            if (cs_n != 0) begin n_fail++; $display("FAIL oob_rom_access line=%0d got %0d cycles required 0", lines[k], cs_n); end
            for (int h = 16; h < 48; h += 7) begin
                hcount = 10'(h); tick();
                n_cmp++;
                if (pixel_valid !== 1'b0) begin
                    n_fail++; $display("FAIL oob_pixel line=%0d h=%0d got %b required 0", lines[k], h, pixel_valid);
                end
            end
        end
    endtask

    task automatic test_abort();
        logic [15:0] sc;
        int busy_n, r2;
        logic [8:0] exp;
        sc = rand_score();
        load_score(sc);
        start_line(8 + int'($urandom_range(5, 15)));
        repeat (10) tick();
        start_line(12);
        busy_n = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) busy_n++;
            tick();
        end
        n_cmp++;
        if (busy_n != 33) begin n_fail++; $display("FAIL abort_busy_len got %0d required 33", busy_n); end
        for (int h = 15; h <= 48; h++) begin
            hcount = 10'(h); tick();
            exp = exp_pix(sc, 4, 1'b1, h);
            n_cmp++;
            if ({pixel_valid, pixel_index} !== exp) begin
                n_fail++; $display("FAIL abort_row4 h=%0d got %h required %h", h, {pixel_valid, pixel_index}, exp);
            end
        end
        // restart that arrives in the drain cycle
        r2 = int'($urandom_range(0, 15));
        start_line(8);
        repeat (32) tick();
        start_line(8 + r2);
        repeat (36) tick();
        for (int h = 16; h < 48; h++) begin
            hcount = 10'(h); tick();
            exp = exp_pix(sc, r2, 1'b1, h);
            n_cmp++;
            if ({pixel_valid, pixel_index} !== exp) begin
                n_fail++; $display("FAIL abort_drain row=%0d h=%0d got %h required %h", r2, h, {pixel_valid, pixel_index}, exp);
            end
        end
        // abort into an out-of-band line cancels everything
        start_line(8);
        repeat (5) tick();
        start_line(40);
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_cancel_busy got %b required 0", busy); end
        for (int h = 16; h < 48; h += 5) begin
            hcount = 10'(h); tick();
            n_cmp++;
            if (pixel_valid !== 1'b0) begin n_fail++; $display("FAIL abort_cancel_pixel h=%0d got %b required 0", h, pixel_valid); end
        end
    endtask

    task automatic test_invalid_digit();
        logic [15:0] sc;
        int row;
        logic [8:0] exp;
        sc = rand_score();
        sc[7:4] = 4'($urandom_range(10, 15));
        row = int'($urandom_range(0, 15));
        load_score(sc);
        start_line(8 + row);
        repeat (36) tick();
        for (int h = 16; h < 48; h++) begin
            hcount = 10'(h); tick();
            exp = exp_pix(sc, row, 1'b1, h);
            n_cmp++;
            if ({pixel_valid, pixel_index} !== exp) begin
                n_fail++; $display("FAIL invalid_digit sc=%h h=%0d got %h required %h", sc, h, {pixel_valid, pixel_index}, exp);
            end
        end
    endtask

    task automatic test_score_load_midfetch();
        logic [15:0] s1, s2;
        int r1, r2;
        logic [8:0] exp;
        s1 = rand_score(); s2 = rand_score() ^ 16'h1111;
        r1 = int'($urandom_range(0, 15)); r2 = int'($urandom_range(0, 15));
        load_score(s1);
        start_line(8 + r1);
        repeat (5) tick();
        load_score(s2);
        repeat (35) tick();
        for (int h = 16; h < 48; h++) begin
            hcount = 10'(h); tick();
            exp = exp_pix(s1, r1, 1'b1, h);
            n_cmp++;
            if ({pixel_valid, pixel_index} !== exp) begin
                n_fail++; $display("FAIL midload_current h=%0d got %h required %h", h, {pixel_valid, pixel_index}, exp);
            end
        end
        start_line(8 + r2);
        repeat (36) tick();
        for (int h = 16; h < 48; h++) begin
            hcount = 10'(h); tick();
            exp = exp_pix(s2, r2, 1'b1, h);
            n_cmp++;
            if ({pixel_valid, pixel_index} !== exp) begin
                n_fail++; $display("FAIL midload_next h=%0d got %h required %h", h, {pixel_valid, pixel_index}, exp);
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [15:0] scs[4];
        int row;
        logic [8:0] exp;
        scs[0] = 16'h0007; scs[1] = 16'h0000; scs[2] = 16'h0100; scs[3] = 16'h0090;
        for (int k = 0; k < 4; k++) begin
            row = int'($urandom_range(0, 15));
            load_score(scs[k]);
            start_line(8 + row);
            repeat (36) tick();
            for (int h = 16; h < 48; h++) begin
                hcount = 10'(h); tick();
                exp = exp_pix(scs[k], row, 1'b1, h);
                n_cmp++;
                if ({pixel_valid, pixel_index} !== exp) begin
                    n_fail++; $display("FAIL leading_zero sc=%h h=%0d got %h required %h", scs[k], h, {pixel_valid, pixel_index}, exp);
                end
            end
        end
    endtask

    task automatic test_reset_midfetch();
        int row;
        logic [8:0] exp;
        load_score(rand_score());
        start_line(8 + int'($urandom_range(0, 15)));
        repeat (6) tick();
        reset = 1'b1; tick();
        n_cmp++;
        if ({rom_address, rom_chipselect, rom_clken, pixel_valid, pixel_index, busy} !== 23'd0) begin
            n_fail++; $display("FAIL reset_midfetch got addr=%0d cs=%b busy=%b required all 0", rom_address, rom_chipselect, busy);
        end
        reset = 1'b0;
        repeat (40) tick();
        for (int h = 16; h < 48; h += 3) begin
            hcount = 10'(h); tick();
            n_cmp++;
            if (pixel_valid !== 1'b0) begin n_fail++; $display("FAIL reset_midfetch_pixel h=%0d got %b required 0", h, pixel_valid); end
        end
        // the score latch was cleared too
        row = int'($urandom_range(0, 15));
        start_line(8 + row);
        repeat (36) tick();
        for (int h = 16; h < 48; h++) begin
            hcount = 10'(h); tick();
            exp = exp_pix(16'h0000, row, 1'b1, h);
            n_cmp++;
            if ({pixel_valid, pixel_index} !== exp) begin
                n_fail++; $display("FAIL reset_score_latch h=%0d got %h required %h", h, {pixel_valid, pixel_index}, exp);
            end
        end
    endtask

    task automatic test_rom_bounds();
        n_cmp++;
        if (rom_oob != 0) begin n_fail++; $display("FAIL rom_bounds got %0d accesses above 1279 required 0", rom_oob); end
    endtask

    initial begin
        for (int a = 0; a < 2048; a++) rom[a] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        reset = 1'b1; score_bcd = 16'h0000; score_load = 1'b0;
        line_start = 1'b0; line_num = 10'd0; hcount = 10'd0;
        test_reset();
        test_fetch_addresses();
        test_pixels();
        test_out_of_band();
        test_abort();
        test_invalid_digit();
        test_score_load_midfetch();
        test_leading_zero();
        test_reset_midfetch();
        test_rom_bounds();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/score_digit_fetcher.md
Name: score_digit_fetcher

Overview:
- Read-side client of the 1280x8 single-port digit-glyph ROM (10 glyphs, 8 wide x 16 tall, one 8-bit palette index per pixel).
- Latches a BCD score once per frame.
- On each scanline inside the score band, it reads that line's glyph row for every digit into a line buffer, then streams palette indices to the VGA compositor by hcount.
- Sits between the glyph ROM and the pixel mux.

Parameters:
- N_DIGITS, 4, number of BCD digits displayed (1..8).
- X0, 16, first pixel column of the score field (10-bit).
- Y0, 8, first scanline of the score band (10-bit).
- TRANSPARENT, 8'h00, palette index treated as see-through.

Ports:
- clk  in  1  system clock (only clock)
- reset  in  1  synchronous, active-high reset
- score_bcd  in  4*N_DIGITS  score, digit 0 = least significant nibble
- score_load  in  1  frame-start pulse; latches score_bcd
- line_start  in  1  one-cycle pulse at start of horizontal blanking
- line_num  in  10  scanline to be displayed next, valid with line_start
- hcount  in  10  current active-video column
- rom_address  out  11  glyph ROM address
- rom_chipselect  out  1  high while fetching
- rom_clken  out  1  ROM clock enable, high while fetching
- rom_readdata  in  8  ROM data, valid one cycle after the address is presented
- pixel_valid  out  1  pixel is inside the score field and opaque
- pixel_index  out  8  palette index
- busy  out  1  fetch in progress

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port name reset.
- Reset values:
  - rom_address=0, rom_chipselect=0, rom_clken=0.
  - pixel_valid=0, pixel_index=0, busy=0.
  - Latched score=0, line_valid=0, FSM=IDLE.
- ROM address: {digit[3:0], row[3:0], col[2:0]}, so digit*128 + row*8 + col. The maximum address is 1279. The ROM is never written.
- score_load: the latched score updates only on this pulse. Mid-frame changes to score_bcd are invisible until the next pulse.
- FSM states:
  - IDLE:
    - On line_start, clear line_valid.
    - If Y0 <= line_num < Y0+16, capture row = line_num-Y0 and go to FETCH with slot 0.
    - Otherwise stay in IDLE.
  - FETCH:
    - Each cycle, present the address for (slot>>3, slot[2:0]). Slot counts 0..8*N_DIGITS-1.
    - The write to buffer[slot-1] uses rom_readdata from the previous cycle, through a 1-stage valid/slot pipe.
    - A digit nibble >9 issues no meaningful read; its 8 buffer bytes are forced to TRANSPARENT.
    - After the last address, go to DRAIN.
  - DRAIN: one cycle that writes the final byte, sets line_valid, and returns to IDLE.
  - Fetch length is 8*N_DIGITS+1 cycles (33 at default). busy is high in FETCH and DRAIN.
- line_start during FETCH/DRAIN: abort, discard the pipe, clear line_valid, and restart per the IDLE rules with the new line_num. No stale write may land after the abort.
- score_load during FETCH: takes effect for the next fetch only. The current line uses the latch value captured at fetch start.
- Pixel path, 1-cycle registered latency:
  - idx = hcount-X0.
  - In range when X0 <= hcount < X0+8*N_DIGITS and line_valid=1.
  - pixel_index = buffer[idx].
  - pixel_valid = in_range && buffer[idx] != TRANSPARENT.
  - Out of range: pixel_valid=0, pixel_index=0.
- Buffer ordering: slot 0 is the most significant digit, drawn leftmost.
- Reset mid-fetch: immediate return to IDLE. Outputs go to reset values and nothing is displayed until the next completed fetch.

Optional Feature:
- Macro: SCORE_LEADING_ZERO_BLANK_EN.
- Defined: zero digits to the left of the first nonzero digit are rendered TRANSPARENT without ROM access. The least significant digit always renders, so score 0 shows a single "0".
- Undefined: all N_DIGITS digits render, including leading zeros.

Decomposition:
- Package score_digit_pkg holds:
  - constants GLYPH_W=8, GLYPH_H=16, GLYPH_BYTES=128, ROM_AW=11, ROM_DW=8;
  - the fetch_state_t enum {IDLE, FETCH, DRAIN};
  - a function forming the ROM address from (digit, row, col).
- One sub-module is natural: score_line_buf, an 8*N_DIGITS x 8 buffer with a synchronous write port and a registered read port.

Test Plan:
- Reset, score_load with 0x1234, line_start with line_num=8 -> 33-cycle fetch. Addresses 128..135, 256..263, 384..391, 512..519 in order. busy is high for 33 cycles.
- ROM model with byte = address[7:0]; line_num=10, score 0x0905; sweep hcount 16..47 -> pixel_index one cycle later equals the glyph row bytes (row 2). pixel_valid=0 where the byte is 0x00 and at hcount 15 and 48.
- line_num=7 and line_num=24 -> no ROM access (rom_chipselect stays 0) and pixel_valid stays 0.
- Second line_start 10 cycles into a fetch, new line_num=12 -> fetch restarts at row 4, total 33 more cycles, buffer holds only row-4 data.
- score_bcd nibble 0xA in digit 1 -> its 8 columns give pixel_valid=0. score_load changed mid-fetch -> the current line is unaffected and the next line uses the new score.
- With SCORE_LEADING_ZERO_BLANK_EN and score 0x0007 -> only the rightmost 8 columns are opaque. Without the macro -> 0007 is fully drawn.
